// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default 50 MHz timing
// constants and the frame parity helper. The data-in receiver imports this too.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE            = 3'd0,
        ST_INIT_RTS        = 3'd1,
        ST_WAIT_FIRST_EDGE = 3'd2,
        ST_TX_BITS         = 3'd3,
        ST_WAIT_ACK        = 3'd4,
        ST_DONE            = 3'd5,
        ST_ERROR           = 3'd6
    } ps2_tx_state_t;

    localparam int TIMER_WIDTH     = 20;
    localparam int BIT_CNT_WIDTH   = 4;
    localparam int MAX_TIMER_VALUE = (1 << TIMER_WIDTH) - 1;

    localparam int DEFAULT_CLK_HOLD_CYCLES      = 5050;    // 101 us
    localparam int DEFAULT_START_TIMEOUT_CYCLES = 750000;  // 15 ms
    localparam int DEFAULT_XFER_TIMEOUT_CYCLES  = 100000;  // 2 ms

    // bit_cnt value at which the next falling edge hands the line over for the stop bit
    localparam logic [BIT_CNT_WIDTH-1:0] STOP_BIT_CNT = 4'd9;

    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE = {{(TIMER_WIDTH-1){1'b0}}, 1'b1};

    // Parity bit that makes the total count of ones in {parity, data} odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_timeout_counter.sv
// Cycle timer shared by all timed phases of the PS/2 transmitter.
// expired is high during the terminal_count-th enabled cycle after a clear.
module ps2_timeout_counter
    import ps2_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enable,
    input  logic [TIMER_WIDTH-1:0] terminal_count,
    output logic                   expired
);

    logic [TIMER_WIDTH-1:0] count_reg;

    assign expired = enable && (count_reg == (terminal_count - TIMER_ONE));

    // Saturates once expired so a late edge cannot wrap the count around.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + TIMER_ONE;
        end
    end

endmodule

// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 transmitter: request-to-send, start bit, LSB-first byte,
// odd parity, stop bit and device ACK, with start and transfer timeouts.
module ps2_command_out
    import ps2_pkg::*;
#(
    parameter int CLK_HOLD_CYCLES      = DEFAULT_CLK_HOLD_CYCLES,
    parameter int START_TIMEOUT_CYCLES = DEFAULT_START_TIMEOUT_CYCLES,
    parameter int XFER_TIMEOUT_CYCLES  = DEFAULT_XFER_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    input  logic       ps2_clk_posedge,
    input  logic       ps2_clk_negedge,
    input  logic       ps2_data,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    if (CLK_HOLD_CYCLES < 2 || CLK_HOLD_CYCLES > MAX_TIMER_VALUE ||
        START_TIMEOUT_CYCLES < 1 || START_TIMEOUT_CYCLES > MAX_TIMER_VALUE ||
        XFER_TIMEOUT_CYCLES < 1 || XFER_TIMEOUT_CYCLES > MAX_TIMER_VALUE) begin : g_bad_config
        $error("ps2_command_out: timing parameter outside the 20-bit timer range");
    end

    // The hold timer expires one cycle early; that cycle raises the start bit.
    localparam logic [TIMER_WIDTH-1:0] HOLD_TC  = TIMER_WIDTH'(CLK_HOLD_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] START_TC = TIMER_WIDTH'(START_TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] XFER_TC  = TIMER_WIDTH'(XFER_TIMEOUT_CYCLES);

    ps2_tx_state_t            state_reg;
    logic [8:0]               shift_reg;
    logic [BIT_CNT_WIDTH-1:0] bit_cnt_reg;
    logic                     clk_low_reg;
    logic                     data_low_reg;
    logic                     busy_reg;
    logic                     sent_reg;
    logic                     timeout_reg;

    logic                     timer_clear;
    logic                     timer_enable;
    logic [TIMER_WIDTH-1:0]   timer_terminal;
    logic                     timer_expired;

    assign ps2_clk_drive_low             = clk_low_reg;
    assign ps2_data_drive_low            = data_low_reg;
    assign busy                          = busy_reg;
    assign command_was_sent              = sent_reg;
    assign error_communication_timed_out = timeout_reg;

    // The timer restarts on every phase change except between bits: the
    // transfer timeout spans TX_BITS and WAIT_ACK as a whole.
    always_comb begin
        timer_clear    = 1'b1;
        timer_enable   = 1'b0;
        timer_terminal = XFER_TC;
        case (state_reg)
            ST_INIT_RTS: begin
                timer_clear    = data_low_reg;
                timer_enable   = 1'b1;
                timer_terminal = HOLD_TC;
            end
            ST_WAIT_FIRST_EDGE: begin
                timer_clear    = ps2_clk_negedge;
                timer_enable   = 1'b1;
                timer_terminal = START_TC;
            end
            ST_TX_BITS, ST_WAIT_ACK: begin
                timer_clear  = 1'b0;
                timer_enable = 1'b1;
            end
            default: begin
                timer_clear = 1'b1;
            end
        endcase
    end

    ps2_timeout_counter u_timer (
        .clk            (clk),
        .reset          (reset),
        .clear          (timer_clear),
        .enable         (timer_enable),
        .terminal_count (timer_terminal),
        .expired        (timer_expired)
    );

    // Edge strobes are tested before the timer so an edge wins a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            clk_low_reg  <= 1'b0;
            data_low_reg <= 1'b0;
            busy_reg     <= 1'b0;
            sent_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    clk_low_reg  <= 1'b0;
                    data_low_reg <= 1'b0;
                    sent_reg     <= 1'b0;
                    timeout_reg  <= 1'b0;
                    busy_reg     <= 1'b0;
                    if (send_command) begin
                        shift_reg   <= {odd_parity(the_command), the_command};
                        bit_cnt_reg <= '0;
                        clk_low_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_INIT_RTS;
                    end
                end

                ST_INIT_RTS: begin
                    if (data_low_reg) begin
                        clk_low_reg <= 1'b0;
                        state_reg   <= ST_WAIT_FIRST_EDGE;
                    end else if (timer_expired) begin
                        data_low_reg <= 1'b1;
                    end
                end

                ST_WAIT_FIRST_EDGE: begin
                    if (ps2_clk_negedge) begin
                        data_low_reg <= ~shift_reg[0];
                        shift_reg    <= {1'b0, shift_reg[8:1]};
                        bit_cnt_reg  <= 4'd1;
                        state_reg    <= ST_TX_BITS;
                    end else if (timer_expired) begin
                        clk_low_reg  <= 1'b0;
                        data_low_reg <= 1'b0;
                        timeout_reg  <= 1'b1;
                        state_reg    <= ST_ERROR;
                    end
                end

                ST_TX_BITS: begin
                    if (ps2_clk_negedge) begin
                        if (bit_cnt_reg == STOP_BIT_CNT) begin
                            data_low_reg <= 1'b0;
                            state_reg    <= ST_WAIT_ACK;
                        end else begin
                            data_low_reg <= ~shift_reg[0];
                            shift_reg    <= {1'b0, shift_reg[8:1]};
                            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                        end
                    end else if (timer_expired) begin
                        clk_low_reg  <= 1'b0;
                        data_low_reg <= 1'b0;
                        timeout_reg  <= 1'b1;
                        state_reg    <= ST_ERROR;
                    end
                end

                ST_WAIT_ACK: begin
                    // The stop-bit sample itself shows data high; only a low line is the ACK.
                    if (ps2_clk_posedge && !ps2_data) begin
                        sent_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else if (timer_expired) begin
                        clk_low_reg  <= 1'b0;
                        data_low_reg <= 1'b0;
                        timeout_reg  <= 1'b1;
                        state_reg    <= ST_ERROR;
                    end
                end

                ST_DONE, ST_ERROR: begin
                    clk_low_reg  <= 1'b0;
                    data_low_reg <= 1'b0;
                    if (!send_command) begin
                        sent_reg    <= 1'b0;
                        timeout_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        state_reg   <= ST_IDLE;
                    end
                end

                default: begin
                    clk_low_reg  <= 1'b0;
                    data_low_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
